// File: rtl/vexii_pkg.sv
// Shared opcode/funct3 encodings and FSM state type for the vexiiriscv_wb hart.
package vexii_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0, F3_LH  = 3'd1, F3_LW  = 3'd2, F3_LBU  = 3'd4, F3_LHU = 3'd5;
    localparam logic [2:0] F3_MUL  = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_DIV,
        ST_WB
    } state_e;

endpackage

// File: rtl/vexii_divider.sv
// Iterative restoring divider: one quotient bit per cycle, 32 cycles per operation.
module vexii_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        want_rem,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    logic [31:0] quo, rem, dvs;
    logic [5:0]  cnt;
    logic        neg_q, neg_r, rem_sel;
    logic        a_neg, b_neg;
    logic [32:0] shifted, diff;

    assign a_neg   = is_signed & dividend[31];
    assign b_neg   = is_signed & divisor[31];
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= 6'd32;
        end else if (busy) begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Divide-by-zero keeps the quotient un-negated so it stays all ones.
    always_ff @(posedge clk) begin
        if (start) begin
            quo     <= a_neg ? -dividend : dividend;
            dvs     <= b_neg ? -divisor : divisor;
            rem     <= '0;
            neg_q   <= (a_neg ^ b_neg) & (divisor != 32'd0);
            neg_r   <= a_neg;
            rem_sel <= want_rem;
        end else if (busy) begin
            quo <= {quo[30:0], ~diff[32]};
            rem <= diff[32] ? shifted[31:0] : diff[31:0];
        end
    end

    assign result = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

endmodule

// File: rtl/vexiiriscv_wb.sv
// Multicycle RV32IM hart with separate Wishbone classic fetch and load/store masters.
module vexiiriscv_wb
    import vexii_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PrivilegedPlugin_logic_rdtime,
    input  logic        PrivilegedPlugin_logic_harts_0_int_m_timer,
    input  logic        PrivilegedPlugin_logic_harts_0_int_m_software,
    input  logic        PrivilegedPlugin_logic_harts_0_int_m_external,
    output logic        LsuCachelessWishbonePlugin_logic_bridge_down_CYC,
    output logic        LsuCachelessWishbonePlugin_logic_bridge_down_STB,
    output logic        LsuCachelessWishbonePlugin_logic_bridge_down_WE,
    output logic [29:0] LsuCachelessWishbonePlugin_logic_bridge_down_ADR,
    output logic [31:0] LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MOSI,
    input  logic [31:0] LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MISO,
    output logic [3:0]  LsuCachelessWishbonePlugin_logic_bridge_down_SEL,
    input  logic        LsuCachelessWishbonePlugin_logic_bridge_down_ACK,
    input  logic        LsuCachelessWishbonePlugin_logic_bridge_down_ERR,
    output logic [2:0]  LsuCachelessWishbonePlugin_logic_bridge_down_CTI,
    output logic [1:0]  LsuCachelessWishbonePlugin_logic_bridge_down_BTE,
    output logic        FetchCachelessWishbonePlugin_logic_bridge_bus_CYC,
    output logic        FetchCachelessWishbonePlugin_logic_bridge_bus_STB,
    output logic        FetchCachelessWishbonePlugin_logic_bridge_bus_WE,
    output logic [29:0] FetchCachelessWishbonePlugin_logic_bridge_bus_ADR,
    output logic [31:0] FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MOSI,
    input  logic [31:0] FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MISO,
    output logic [3:0]  FetchCachelessWishbonePlugin_logic_bridge_bus_SEL,
    input  logic        FetchCachelessWishbonePlugin_logic_bridge_bus_ACK,
    input  logic        FetchCachelessWishbonePlugin_logic_bridge_bus_ERR,
    output logic [2:0]  FetchCachelessWishbonePlugin_logic_bridge_bus_CTI,
    output logic [1:0]  FetchCachelessWishbonePlugin_logic_bridge_bus_BTE
);
    state_e      state, state_nxt;
    logic [31:0] pc, ir, npc, wb_val;
    logic        wb_en;
    logic [1:0]  ea_lo;
    logic [31:0] rf [0:31];
    logic        ibus_cyc, dbus_cyc, dbus_we;
    logic [29:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;

    logic        i_ack, d_ack;
    logic [31:0] d_miso;
    assign i_ack  = FetchCachelessWishbonePlugin_logic_bridge_bus_ACK;
    assign d_ack  = LsuCachelessWishbonePlugin_logic_bridge_down_ACK;
    assign d_miso = LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MISO;

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign f7    = ir[31:25];
    assign rs1v  = rf[rs1];
    assign rs2v  = rf[rs2];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic is_muldiv, is_div, is_mem;
    assign is_muldiv = (opc == OPC_OP) && (f7 == F7_MULDIV);
    assign is_div    = is_muldiv & f3[2];
    assign is_mem    = (opc == OPC_LOAD) || (opc == OPC_STORE);

    logic [31:0] op_b, alu;
    assign op_b = (opc == OPC_OP) ? rs2v : imm_i;

    always_comb begin
        alu = '0;
        case (f3)
            F3_ADD:  alu = ((opc == OPC_OP) && ir[30]) ? rs1v - op_b : rs1v + op_b;
            F3_SLL:  alu = rs1v << op_b[4:0];
            F3_SLT:  alu = {31'b0, $signed(rs1v) < $signed(op_b)};
            F3_SLTU: alu = {31'b0, rs1v < op_b};
            F3_XOR:  alu = rs1v ^ op_b;
            F3_SR:   alu = ir[30] ? 32'($signed(rs1v) >>> op_b[4:0]) : rs1v >> op_b[4:0];
            F3_OR:   alu = rs1v | op_b;
            default: alu = rs1v & op_b;
        endcase
    end

    // 33x33 signed product covers all four MUL variants via the extension bit.
    logic signed [32:0] mul_a, mul_b;
    logic signed [65:0] mul_p;
    logic [31:0]        mul_res;
    assign mul_a   = {(f3 != F3_MULHU) & rs1v[31], rs1v};
    assign mul_b   = {~f3[1] & rs2v[31], rs2v};
    assign mul_p   = mul_a * mul_b;
    assign mul_res = (f3 == F3_MUL) ? mul_p[31:0] : mul_p[63:32];

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = rs1v == rs2v;
            F3_BNE:  taken = rs1v != rs2v;
            F3_BLT:  taken = $signed(rs1v) < $signed(rs2v);
            F3_BGE:  taken = $signed(rs1v) >= $signed(rs2v);
            F3_BLTU: taken = rs1v < rs2v;
            F3_BGEU: taken = rs1v >= rs2v;
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] exe_val, exe_npc;
    logic        exe_en;
    always_comb begin
        exe_val = '0;
        exe_en  = 1'b0;
        exe_npc = pc + 32'd4;
        case (opc)
            OPC_LUI:    begin exe_val = imm_u;      exe_en = 1'b1; end
            OPC_AUIPC:  begin exe_val = pc + imm_u; exe_en = 1'b1; end
            OPC_JAL:    begin exe_val = pc + 32'd4; exe_en = 1'b1; exe_npc = (pc + imm_j) & ~32'd1; end
            OPC_JALR:   begin exe_val = pc + 32'd4; exe_en = 1'b1; exe_npc = (rs1v + imm_i) & ~32'd1; end
            OPC_BRANCH: if (taken) exe_npc = (pc + imm_b) & ~32'd1;
            OPC_OP_IMM: begin exe_val = alu; exe_en = 1'b1; end
            OPC_OP:     begin exe_val = is_muldiv ? mul_res : alu; exe_en = 1'b1; end
            OPC_LOAD:   exe_en = 1'b1;
            default:    exe_en = 1'b0;
        endcase
    end

    // Lane steering: bytes/halves replicated across the bus, SEL picks the lane.
    logic [31:0] ea, st_dat, ld_shift, ld_val;
    logic [3:0]  sel;
    logic [15:0] ld_half;
    assign ea = rs1v + ((opc == OPC_STORE) ? imm_s : imm_i);
    always_comb begin
        case (f3[1:0])
            2'b00:   begin sel = 4'b0001 << ea[1:0];         st_dat = {4{rs2v[7:0]}}; end
            2'b01:   begin sel = 4'b0011 << {ea[1], 1'b0};   st_dat = {2{rs2v[15:0]}}; end
            default: begin sel = 4'hF;                       st_dat = rs2v; end
        endcase
    end

    assign ld_shift = d_miso >> {ea_lo, 3'b000};
    assign ld_half  = ea_lo[1] ? d_miso[31:16] : d_miso[15:0];
    always_comb begin
        case (f3)
            F3_LB:   ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_val = {24'b0, ld_shift[7:0]};
            F3_LHU:  ld_val = {16'b0, ld_half};
            default: ld_val = d_miso;
        endcase
    end

    logic        div_busy, div_done;
    logic [31:0] div_res;
    vexii_divider u_div (
        .clk      (clk),
        .rst      (reset),
        .start    ((state == ST_EXEC) && is_div),
        .is_signed(~f3[0]),
        .want_rem (f3[1]),
        .dividend (rs1v),
        .divisor  (rs2v),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_res)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: if (ibus_cyc && i_ack) state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = is_mem ? ST_MEM : (is_div ? ST_DIV : ST_WB);
            ST_MEM:   if (d_ack) state_nxt = ST_WB;
            ST_DIV:   if (div_done) state_nxt = ST_WB;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // Bus strobes are registered so reset drops them and each ACK is followed by an idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ibus_cyc <= 1'b0;
            dbus_cyc <= 1'b0;
            dbus_we  <= 1'b0;
            pc       <= RESET_PC;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (state == ST_FETCH && ibus_cyc && i_ack) ibus_cyc <= 1'b0;
            else if (state_nxt == ST_FETCH)             ibus_cyc <= 1'b1;
            if (state == ST_MEM && d_ack)        dbus_cyc <= 1'b0;
            else if (state == ST_EXEC && is_mem) dbus_cyc <= 1'b1;
            if (state == ST_EXEC) dbus_we <= is_mem && (opc == OPC_STORE);
            if (state == ST_WB) begin
                pc <= npc;
                if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_FETCH && ibus_cyc && i_ack) ir <= FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MISO;
        if (state == ST_EXEC) begin
            wb_val   <= exe_val;
            wb_en    <= exe_en;
            npc      <= exe_npc;
            ea_lo    <= ea[1:0];
            dbus_adr <= ea[31:2];
            dbus_dat <= (opc == OPC_STORE) ? st_dat : 32'd0;
            dbus_sel <= sel;
        end
        if (state == ST_MEM && d_ack) wb_val <= ld_val;
        if (state == ST_DIV && div_done) wb_val <= div_res;
    end

    assign FetchCachelessWishbonePlugin_logic_bridge_bus_CYC      = ibus_cyc;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_STB      = ibus_cyc;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_WE       = 1'b0;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_ADR      = pc[31:2];
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MOSI = '0;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_SEL      = 4'hF;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_CTI      = '0;
    assign FetchCachelessWishbonePlugin_logic_bridge_bus_BTE      = '0;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_CYC       = dbus_cyc;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_STB       = dbus_cyc;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_WE        = dbus_we;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_ADR       = dbus_adr;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MOSI  = dbus_dat;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_SEL       = dbus_sel;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_CTI       = '0;
    assign LsuCachelessWishbonePlugin_logic_bridge_down_BTE       = '0;

    logic unused_inputs;
    assign unused_inputs = ^{PrivilegedPlugin_logic_rdtime,
                             PrivilegedPlugin_logic_harts_0_int_m_timer,
                             PrivilegedPlugin_logic_harts_0_int_m_software,
                             PrivilegedPlugin_logic_harts_0_int_m_external,
                             LsuCachelessWishbonePlugin_logic_bridge_down_ERR,
                             FetchCachelessWishbonePlugin_logic_bridge_bus_ERR,
                             div_busy, ld_shift[31:8], mul_p[65:64]};

endmodule

// File: tb/tb_vexiiriscv_wb.sv
// Scoreboard bench: a directed program whose stores expose register results on the data bus.
module tb_vexiiriscv_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        d_cyc, d_stb, d_we, d_ack, d_err;
    logic [29:0] d_adr;
    logic [31:0] d_mosi, d_miso;
    logic [3:0]  d_sel;
    logic [2:0]  d_cti;
    logic [1:0]  d_bte;
    logic        i_cyc, i_stb, i_we, i_ack, i_err;
    logic [29:0] i_adr;
    logic [31:0] i_mosi, i_miso;
    logic [3:0]  i_sel;
    logic [2:0]  i_cti;
    logic [1:0]  i_bte;

    always #5 clk = ~clk;

    vexiiriscv_wb #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .PrivilegedPlugin_logic_rdtime(64'd0),
        .PrivilegedPlugin_logic_harts_0_int_m_timer(1'b0),
        .PrivilegedPlugin_logic_harts_0_int_m_software(1'b0),
        .PrivilegedPlugin_logic_harts_0_int_m_external(1'b0),
        .LsuCachelessWishbonePlugin_logic_bridge_down_CYC(d_cyc),
        .LsuCachelessWishbonePlugin_logic_bridge_down_STB(d_stb),
        .LsuCachelessWishbonePlugin_logic_bridge_down_WE(d_we),
        .LsuCachelessWishbonePlugin_logic_bridge_down_ADR(d_adr),
        .LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MOSI(d_mosi),
        .LsuCachelessWishbonePlugin_logic_bridge_down_DAT_MISO(d_miso),
        .LsuCachelessWishbonePlugin_logic_bridge_down_SEL(d_sel),
        .LsuCachelessWishbonePlugin_logic_bridge_down_ACK(d_ack),
        .LsuCachelessWishbonePlugin_logic_bridge_down_ERR(d_err),
        .LsuCachelessWishbonePlugin_logic_bridge_down_CTI(d_cti),
        .LsuCachelessWishbonePlugin_logic_bridge_down_BTE(d_bte),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_CYC(i_cyc),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_STB(i_stb),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_WE(i_we),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_ADR(i_adr),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MOSI(i_mosi),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_DAT_MISO(i_miso),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_SEL(i_sel),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_ACK(i_ack),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_ERR(i_err),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_CTI(i_cti),
        .FetchCachelessWishbonePlugin_logic_bridge_bus_BTE(i_bte)
    );

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat;
        int          nxt;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] prog [0:63];
    int          total = 0;
    int          bad = 0;
    logic        rel = 1'b0;
    logic        mon_done = 1'b0;

    localparam logic [6:0] OPI = 7'b0010011, LUI = 7'b0110111, LD = 7'b0000011;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic push(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int lat, input int nxt);
        exp_t e;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.lat = lat; e.nxt = nxt;
        sbq.push_back(e);
    endtask

    // Instruction bus: ACK one cycle after STB.
    initial begin : ibus_resp
        int iw;
        iw = 0;
        i_ack = 1'b0;
        i_miso = '0;
        forever begin
            @(posedge clk); #1;
            i_ack = 1'b0;
            if (i_cyc && i_stb) begin
                if (iw == 1) begin
                    i_ack = 1'b1;
                    i_miso = prog[i_adr[5:0]];
                    iw = 0;
                end else iw++;
            end else iw = 0;
        end
    end

    initial begin : dbus_mon
        exp_t e;
        int   n;
        wait (rel);
        while (sbq.size() > 0) begin
            n = 0;
            while (!(d_cyc && d_stb) && n < 400) begin @(posedge clk); #1; n++; end
            if (!(d_cyc && d_stb)) begin
                total++; bad++;
                $display("FAIL dbus_req: no request seen, %0d expected pending", sbq.size());
                break;
            end
            e = sbq.pop_front();
            chk("dbus_adr", 32'(d_adr), 32'(e.adr));
            chk("dbus_we", 32'(d_we), 32'(e.we));
            chk("dbus_sel", 32'(d_sel), 32'(e.sel));
            if (e.we) chk("dbus_mosi", d_mosi, e.dat);
            for (int k = 0; k < e.lat; k++) begin
                @(posedge clk); #1;
                chk("stall_adr", 32'(d_adr), 32'(e.adr));
                chk("stall_stb", 32'(d_stb), 32'd1);
            end
            d_ack = 1'b1;
            d_miso = e.we ? 32'd0 : e.dat;
            @(posedge clk); #1;
            d_ack = 1'b0;
            chk("dbus_drop", 32'(d_cyc), 32'd0);
            n = 0;
            while (!(i_cyc && i_stb) && n < 20) begin @(posedge clk); #1; n++; end
            chk("next_fetch_cyc", 32'(i_cyc), 32'd1);
            chk("next_fetch_adr", 32'(i_adr), 32'(e.nxt));
        end
        mon_done = 1'b1;
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        d_ack = 1'b0; d_miso = '0; d_err = 1'b0; i_err = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h00000013;
        prog[0]  = enc_u(32'h10000, 2, LUI);
        prog[1]  = enc_i(5, 0, 0, 1, OPI);
        prog[2]  = enc_s(16, 1, 2, 2);
        prog[3]  = enc_i(32'hA5, 0, 0, 3, OPI);
        prog[4]  = enc_s(1, 3, 2, 0);
        prog[5]  = enc_i(2, 2, 1, 4, LD);
        prog[6]  = enc_s(0, 4, 2, 2);
        prog[7]  = enc_u(32'h00010, 5, LUI);
        prog[8]  = enc_r(1, 5, 5, 0, 6);
        prog[9]  = enc_r(1, 5, 5, 3, 7);
        prog[10] = enc_s(4, 6, 2, 2);
        prog[11] = enc_s(8, 7, 2, 2);
        prog[12] = enc_i(-7, 0, 0, 8, OPI);
        prog[13] = enc_i(2, 0, 0, 9, OPI);
        prog[14] = enc_r(1, 9, 8, 4, 10);
        prog[15] = enc_r(1, 9, 8, 6, 11);
        prog[16] = enc_s(12, 10, 2, 2);
        prog[17] = enc_s(16, 11, 2, 2);
        prog[18] = enc_i(5, 0, 0, 12, OPI);
        prog[19] = enc_r(1, 0, 12, 5, 13);
        prog[20] = enc_r(1, 0, 12, 7, 20);
        prog[21] = enc_s(20, 13, 2, 2);
        prog[22] = enc_s(24, 20, 2, 2);
        prog[23] = enc_u(32'h80000, 16, LUI);
        prog[24] = enc_i(-1, 0, 0, 17, OPI);
        prog[25] = enc_r(1, 17, 16, 4, 18);
        prog[26] = enc_r(1, 17, 16, 6, 19);
        prog[27] = enc_s(28, 18, 2, 2);
        prog[28] = enc_s(32, 19, 2, 2);
        prog[29] = enc_u(32'h30000, 14, LUI);
        prog[30] = enc_i(0, 14, 2, 15, LD);
        prog[31] = enc_s(36, 15, 2, 2);
        prog[32] = enc_b(8, 0, 0, 0);
        prog[33] = enc_s(40, 0, 2, 2);
        prog[34] = enc_i(3, 2, 4, 21, LD);
        prog[35] = enc_s(44, 21, 2, 2);
        prog[36] = 32'h0000006F;

        push(1'b1, 30'h04000004, 4'hF, 32'h00000005, 0, 3);
        push(1'b1, 30'h04000000, 4'h2, 32'hA5A5A5A5, 1, 5);
        push(1'b0, 30'h04000000, 4'hC, 32'h80010000, 0, 6);
        push(1'b1, 30'h04000000, 4'hF, 32'hFFFF8001, 2, 7);
        push(1'b1, 30'h04000001, 4'hF, 32'h00000000, 0, 11);
        push(1'b1, 30'h04000002, 4'hF, 32'h00000001, 0, 12);
        push(1'b1, 30'h04000003, 4'hF, 32'hFFFFFFFD, 0, 17);
        push(1'b1, 30'h04000004, 4'hF, 32'hFFFFFFFF, 0, 18);
        push(1'b1, 30'h04000005, 4'hF, 32'hFFFFFFFF, 0, 22);
        push(1'b1, 30'h04000006, 4'hF, 32'h00000005, 0, 23);
        push(1'b1, 30'h04000007, 4'hF, 32'h80000000, 0, 28);
        push(1'b1, 30'h04000008, 4'hF, 32'h00000000, 0, 29);
        push(1'b0, 30'h0C000000, 4'hF, 32'h12345678, 10, 31);
        push(1'b1, 30'h04000009, 4'hF, 32'h12345678, 0, 32);
        push(1'b0, 30'h04000000, 4'h8, 32'h9A000000, 1, 35);
        push(1'b1, 30'h0400000B, 4'hF, 32'h0000009A, 0, 36);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_icyc", 32'(i_cyc), 32'd0);
        chk("rst_dcyc", 32'(d_cyc), 32'd0);
        chk("rst_dwe", 32'(d_we), 32'd0);
        reset = 1'b0;
        rel = 1'b1;

        n = 0;
        while (!(i_cyc && i_stb) && n < 20) begin @(posedge clk); #1; n++; end
        chk("boot_cyc", 32'(i_cyc), 32'd1);
        chk("boot_stb", 32'(i_stb), 32'd1);
        chk("boot_adr", 32'(i_adr), 32'd0);
        chk("boot_we", 32'(i_we), 32'd0);
        chk("boot_sel", 32'(i_sel), 32'hF);

        n = 0;
        while (!mon_done && n < 5000) begin @(posedge clk); #1; n++; end
        if (!mon_done) begin
            total++; bad++;
            $display("FAIL run_timeout: %0d expected transfers never seen", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
